// File: rtl/control_riesgos.sv
// control_riesgos: hazard and sequencing controller for the five-stage pipeline.
// It keeps a shadow copy of register numbers and write/load flags for EX, MEM
// and WB. From that copy it detects load-use stalls, applies branch and jump
// flushes, inserts ID/EX bubbles and picks the EX forwarding sources.
module control_riesgos #(
  parameter int ANCHO_CNT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           id_control,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_usa_rs,
  input  logic                 id_usa_rt,
  input  logic [4:0]           id_dest,
  input  logic                 ex_salto_tomado,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_flush,
  output logic [9:0]           idex_control,
  output logic [1:0]           fwd_a,
  output logic [1:0]           fwd_b,
  output logic [ANCHO_CNT-1:0] cnt_paradas,
  output logic [ANCHO_CNT-1:0] cnt_vaciados
);

  // Shadow pipeline state
  logic [4:0] ex_rs_reg, ex_rt_reg, ex_dest_reg;
  logic       ex_escr_reg, ex_leer_reg;
  logic [4:0] mem_dest_reg;
  logic       mem_escr_reg;
  logic [4:0] wb_dest_reg;
  logic       wb_escr_reg;

  logic [ANCHO_CNT-1:0] cnt_paradas_reg, cnt_vaciados_reg;

  logic parada;
  logic burbuja;
  logic cuenta_parada;
  logic cuenta_vaciado;

  // Operand sources of the instruction in EX, indexed by forwarding port
  logic [4:0] ex_src [2];
  logic [1:0] fwd_sel [2];

  // Load-use hazard: the load in EX writes a register that ID actually reads.
  // Register 0 is hardwired, so a load to it never stalls.
  assign parada = ex_leer_reg && (ex_dest_reg != 5'd0) &&
                  ((id_usa_rs && (id_rs == ex_dest_reg)) ||
                   (id_usa_rt && (id_rt == ex_dest_reg)));

  // Event priority: taken branch, then load-use stall, then jump in ID.
  // While reset is held the controller shows the free-running defaults.
  always_comb begin
    pc_en          = 1'b1;
    ifid_en        = 1'b1;
    ifid_flush     = 1'b0;
    burbuja        = 1'b0;
    cuenta_parada  = 1'b0;
    cuenta_vaciado = 1'b0;
    if (rst_n) begin
      if (ex_salto_tomado) begin
        // Both younger instructions are on the wrong path
        ifid_flush     = 1'b1;
        burbuja        = 1'b1;
        cuenta_vaciado = 1'b1;
      end else if (parada) begin
        pc_en         = 1'b0;
        ifid_en       = 1'b0;
        burbuja       = 1'b1;
        cuenta_parada = 1'b1;
      end else if (id_control[9]) begin
        // The jump proceeds; only the fetched successor is discarded
        ifid_flush     = 1'b1;
        cuenta_vaciado = 1'b1;
      end
    end
  end

  assign idex_control = burbuja ? 10'd0 : id_control;

  assign ex_src[0] = ex_rs_reg;
  assign ex_src[1] = ex_rt_reg;

  // Forwarding per operand port: MEM result wins over WB result, r0 never forwarded
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_sel[gi] = 2'b00;
        if (mem_escr_reg && (mem_dest_reg != 5'd0) && (mem_dest_reg == ex_src[gi]))
          fwd_sel[gi] = 2'b10;
        else if (wb_escr_reg && (wb_dest_reg != 5'd0) && (wb_dest_reg == ex_src[gi]))
          fwd_sel[gi] = 2'b01;
      end
    end
  endgenerate

  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];

  // Shadow pipeline advance; a bubble loads an all-zero EX entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs_reg    <= 5'd0;
      ex_rt_reg    <= 5'd0;
      ex_dest_reg  <= 5'd0;
      ex_escr_reg  <= 1'b0;
      ex_leer_reg  <= 1'b0;
      mem_dest_reg <= 5'd0;
      mem_escr_reg <= 1'b0;
      wb_dest_reg  <= 5'd0;
      wb_escr_reg  <= 1'b0;
    end else begin
      if (burbuja) begin
        ex_rs_reg   <= 5'd0;
        ex_rt_reg   <= 5'd0;
        ex_dest_reg <= 5'd0;
        ex_escr_reg <= 1'b0;
        ex_leer_reg <= 1'b0;
      end else begin
        ex_rs_reg   <= id_rs;
        ex_rt_reg   <= id_rt;
        ex_dest_reg <= id_dest;
        ex_escr_reg <= id_control[5];
        ex_leer_reg <= id_control[4];
      end
      mem_dest_reg <= ex_dest_reg;
      mem_escr_reg <= ex_escr_reg;
      wb_dest_reg  <= mem_dest_reg;
      wb_escr_reg  <= mem_escr_reg;
    end
  end

  // Saturating debug counters for stall cycles and flush events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_paradas_reg  <= '0;
      cnt_vaciados_reg <= '0;
    end else begin
      if (cuenta_parada && (cnt_paradas_reg != {ANCHO_CNT{1'b1}}))
        cnt_paradas_reg <= cnt_paradas_reg + 1'b1;
      if (cuenta_vaciado && (cnt_vaciados_reg != {ANCHO_CNT{1'b1}}))
        cnt_vaciados_reg <= cnt_vaciados_reg + 1'b1;
    end
  end

  assign cnt_paradas  = cnt_paradas_reg;
  assign cnt_vaciados = cnt_vaciados_reg;

endmodule

// File: tb/tb_control_riesgos.sv
// Bench for control_riesgos: directed hazard scenarios followed by random
// instruction streams, compared against a stage-list model of the pipeline.
// A second instance with 4-bit counters exercises counter saturation.
module tb_control_riesgos;

  localparam logic [9:0] C_LW   = 10'h0F0; // FuenteALU, MemaReg, EscrReg, LeerMem
  localparam logic [9:0] C_ADD  = 10'h122; // RegDest, EscrReg, ALUOp=10
  localparam logic [9:0] C_NOP  = 10'h000;
  localparam logic [9:0] C_JUMP = 10'h200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] id_control = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic       id_usa_rs = 1'b0, id_usa_rt = 1'b0;
  logic       ex_salto_tomado = 1'b0;

  logic        pc_en, ifid_en, ifid_flush;
  logic [9:0]  idex_control;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] cnt_paradas, cnt_vaciados;

  logic        s_pc_en, s_ifid_en, s_ifid_flush;
  logic [9:0]  s_idex_control;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [3:0]  s_cnt_paradas, s_cnt_vaciados;

  control_riesgos #(.ANCHO_CNT(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_control(id_control), .id_rs(id_rs), .id_rt(id_rt),
    .id_usa_rs(id_usa_rs), .id_usa_rt(id_usa_rt), .id_dest(id_dest),
    .ex_salto_tomado(ex_salto_tomado), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_control(idex_control), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .cnt_paradas(cnt_paradas), .cnt_vaciados(cnt_vaciados)
  );

  control_riesgos #(.ANCHO_CNT(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_control(id_control), .id_rs(id_rs), .id_rt(id_rt),
    .id_usa_rs(id_usa_rs), .id_usa_rt(id_usa_rt), .id_dest(id_dest),
    .ex_salto_tomado(ex_salto_tomado), .pc_en(s_pc_en), .ifid_en(s_ifid_en),
    .ifid_flush(s_ifid_flush), .idex_control(s_idex_control), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .cnt_paradas(s_cnt_paradas), .cnt_vaciados(s_cnt_vaciados)
  );

  always #5 clk = ~clk;

  // Model: one record per stage in flight, index 0 = EX, 1 = MEM, 2 = WB
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       escr;
    logic       leer;
  } etapa_t;

  etapa_t pipe [3];
  int     n_paradas;
  int     n_vaciados;
  int     n_checks = 0;
  int     n_fail = 0;

  function automatic logic [1:0] fwd_model(input logic [4:0] src);
    if (pipe[1].escr && pipe[1].dest != 0 && pipe[1].dest == src) return 2'b10;
    if (pipe[2].escr && pipe[2].dest != 0 && pipe[2].dest == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) pipe[i] = '{rs: 5'd0, rt: 5'd0, dest: 5'd0, escr: 1'b0, leer: 1'b0};
    n_paradas  = 0;
    n_vaciados = 0;
  endtask

  task automatic check_outputs(input logic e_pc, input logic e_ie, input logic e_fl,
                               input logic [9:0] e_ctl, input logic [1:0] e_fa,
                               input logic [1:0] e_fb);
    chk("pc_en", 32'(pc_en), 32'(e_pc));
    chk("ifid_en", 32'(ifid_en), 32'(e_ie));
    chk("ifid_flush", 32'(ifid_flush), 32'(e_fl));
    chk("idex_control", 32'(idex_control), 32'(e_ctl));
    chk("fwd_a", 32'(fwd_a), 32'(e_fa));
    chk("fwd_b", 32'(fwd_b), 32'(e_fb));
    chk("cnt_paradas", 32'(cnt_paradas), 32'(sat(n_paradas, 65535)));
    chk("cnt_vaciados", 32'(cnt_vaciados), 32'(sat(n_vaciados, 65535)));
    chk("sat_paradas", 32'(s_cnt_paradas), 32'(sat(n_paradas, 15)));
    chk("sat_vaciados", 32'(s_cnt_vaciados), 32'(sat(n_vaciados, 15)));
  endtask

  // One clock cycle: drive ID, check outputs mid-cycle, advance the model at the edge
  task automatic step(input logic [9:0] ctl, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [4:0] dest,
                      input logic salto);
    logic par, burb, flush, evac;
    id_control = ctl; id_rs = rs; id_rt = rt; id_usa_rs = urs; id_usa_rt = urt;
    id_dest = dest; ex_salto_tomado = salto;
    @(negedge clk);
    par   = pipe[0].leer && pipe[0].dest != 0 &&
            ((urs && rs == pipe[0].dest) || (urt && rt == pipe[0].dest));
    burb  = salto || par;
    flush = salto || (!par && ctl[9]);
    evac  = flush;
    check_outputs(!(par && !salto), !(par && !salto), flush, burb ? 10'd0 : ctl,
                  fwd_model(pipe[0].rs), fwd_model(pipe[0].rt));
    $display("step t=%0t ctl=%h rs=%0d rt=%0d dest=%0d salto=%0d -> pc_en=%0d flush=%0d idex=%h fwd=%b/%b par=%0d vac=%0d",
             $time, ctl, rs, rt, dest, salto, pc_en, ifid_flush, idex_control, fwd_a, fwd_b,
             cnt_paradas, cnt_vaciados);
    @(posedge clk);
    if (par && !salto) n_paradas++;
    if (evac) n_vaciados++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (burb) pipe[0] = '{rs: 5'd0, rt: 5'd0, dest: 5'd0, escr: 1'b0, leer: 1'b0};
    else      pipe[0] = '{rs: rs, rt: rt, dest: dest, escr: ctl[5], leer: ctl[4]};
    #1;
  endtask

  // Asynchronous reset in the middle of a cycle, released after the next edge
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    check_outputs(1'b1, 1'b1, 1'b0, id_control, 2'b00, 2'b00);
    $display("reset t=%0t -> pc_en=%0d flush=%0d par=%0d vac=%0d",
             $time, pc_en, ifid_flush, cnt_paradas, cnt_vaciados);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] ctl;
    clear_model();
    // Reset state with a taken branch and a jump presented: outputs stay at defaults
    id_control = C_JUMP; ex_salto_tomado = 1'b1;
    @(posedge clk);
    #1;
    check_outputs(1'b1, 1'b1, 1'b0, C_JUMP, 2'b00, 2'b00);
    ex_salto_tomado = 1'b0;
    rst_n = 1'b1;

    // lw r2 ; add r3,r2,r4 : one stall, then WB forwarding
    step(C_LW,  5'd1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b0);
    step(C_ADD, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0);
    step(C_ADD, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0);
    step(C_NOP, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

    // add r1 ; sub r5,r1,r1 : MEM forwarding on both operands
    step(C_ADD, 5'd6, 5'd7, 1'b1, 1'b1, 5'd1, 1'b0);
    step(C_ADD, 5'd1, 5'd1, 1'b1, 1'b1, 5'd5, 1'b0);
    step(C_NOP, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

    // r1 written by MEM and WB at once, EX reads r1 -> MEM wins
    step(C_ADD, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0);
    step(C_ADD, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b0);
    step(C_ADD, 5'd1, 5'd1, 1'b1, 1'b1, 5'd4, 1'b0);
    step(C_NOP, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

    // lw r0 ; reader of r0 : no stall, no forwarding
    step(C_LW,  5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    step(C_ADD, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b0);
    step(C_NOP, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

    // Taken branch coincides with a load-use stall
    step(C_LW,  5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b0);
    step(C_ADD, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1);
    step(C_NOP, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

    // Jump in ID, then jump in ID while stalled
    step(C_JUMP, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    step(C_LW,   5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b0);
    step(C_JUMP | C_ADD, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    step(C_JUMP | C_ADD, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    step(C_NOP, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

    // Reset while a stall is pending
    step(C_LW, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b0);
    id_control = C_ADD; id_rs = 5'd2; id_usa_rs = 1'b1; id_usa_rt = 1'b0;
    id_rt = 5'd0; id_dest = 5'd3; ex_salto_tomado = 1'b0;
    mid_reset();

    // Repeated load-use pairs drive the narrow counters into saturation
    for (int i = 0; i < 20; i++) begin
      step(C_LW,  5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b0);
      step(C_ADD, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b0);
      step(C_JUMP, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    end

    // Random instruction streams with a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      ctl = 10'($urandom);
      ctl[9] = ($urandom_range(0, 5) == 0);
      step(ctl, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_riesgos.md
# control_riesgos

Hazard and pipeline-sequencing controller for the five-stage segmented processor. Each cycle it inspects the instruction in ID and a private shadow pipeline of destination register, EscrReg and LeerMem for the EX, MEM and WB stages. From these it drives:
- PC and IF/ID enables;
- IF/ID flush;
- the (possibly bubbled) 10-bit control word entering ID/EX;
- the two EX-stage forwarding selects.

It also keeps saturating stall and flush counters for debug.

## Interface
- `ANCHO_CNT`, 16: width of the performance counters.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_control` in 10: decoded control word of the ID instruction. Bit layout:
  - [9] Saltoincond, [8] RegDest, [7] FuenteALU, [6] MemaReg, [5] EscrReg
  - [4] LeerMem, [3] EscrMem, [2] SaltoCond, [1:0] ALUOp
- `id_rs`, `id_rt` in 5 each: source register numbers of the ID instruction.
- `id_usa_rs`, `id_usa_rt` in 1 each: the ID instruction actually reads rs / rt.
- `id_dest` in 5: destination register of the ID instruction, already selected by RegDest.
- `ex_salto_tomado` in 1: conditional branch in EX resolved taken this cycle.
- `pc_en` out 1: PC load enable.
- `ifid_en` out 1: IF/ID load enable.
- `ifid_flush` out 1: IF/ID loads a NOP.
- `idex_control` out 10: control word to load into ID/EX.
- `fwd_a`, `fwd_b` out 2 each: ALU operand A/B source: 00 = ID/EX register value, 10 = EX/MEM result, 01 = MEM/WB result.
- `cnt_paradas` out `ANCHO_CNT`: load-use stall cycles, saturating.
- `cnt_vaciados` out `ANCHO_CNT`: flush events, saturating.

## Operation
**Shadow pipeline.** Registered copies per stage:
- EX: `ex_rs`, `ex_rt`, `ex_dest`, `ex_escr`, `ex_leer`.
- MEM: `mem_dest`, `mem_escr`.
- WB: `wb_dest`, `wb_escr`.

At each edge EX loads the ID values (escr = `id_control[5]`, leer = `id_control[4]`) unless `burbuja` is set, in which case all EX fields load 0. MEM loads EX and WB loads MEM unconditionally.

**Load-use detection** (combinational):
- `parada` = `ex_leer` & `ex_dest`≠0 & ((`id_usa_rs` & `id_rs`==`ex_dest`) | (`id_usa_rt` & `id_rt`==`ex_dest`)).

**Events, in priority order:**
1. `ex_salto_tomado`: `pc_en`=1 (PC takes target), `ifid_en`=1, `ifid_flush`=1, `burbuja`=1. Any simultaneous `parada` or ID jump is ignored (wrong path).
2. `parada`: `pc_en`=0, `ifid_en`=0, `ifid_flush`=0, `burbuja`=1.
3. `id_control[9]` (jump in ID): `pc_en`=1, `ifid_en`=1, `ifid_flush`=1, `burbuja`=0 (the jump itself proceeds).
4. Otherwise: `pc_en`=1, `ifid_en`=1, `ifid_flush`=0, `burbuja`=0.

**Control and forwarding outputs:**
- `idex_control` = `burbuja` ? 10'b0 : `id_control`.
- `fwd_a`:
  - 10 if `mem_escr` & `mem_dest`≠0 & `mem_dest`==`ex_rs`;
  - else 01 if `wb_escr` & `wb_dest`≠0 & `wb_dest`==`ex_rs`;
  - else 00.
- `fwd_b`: same rule using `ex_rt`. MEM has priority over WB.
- Register 0 is never forwarded and never causes a stall.
- The register file is write-before-read, so no ID-stage forwarding exists.

**Counters:**
- `cnt_paradas` increments on each cycle with `parada` & !`ex_salto_tomado`.
- `cnt_vaciados` increments on each cycle with event 1 or event 3.
- Both hold at 2^`ANCHO_CNT`-1.

## Timing
- Shadow registers and counters are the only state. All other outputs are combinational from current inputs and shadow state, valid in the same cycle.
- A load-use stall lasts exactly one cycle. After the edge the load sits in MEM and EX holds a bubble, so `parada` clears. The dependent instruction then gets `fwd`=01 one cycle later, when the load reaches WB.
- A taken branch yields exactly two bubbles: the ID instruction is zeroed into ID/EX, and the IF instruction is NOP'd in IF/ID.
- A jump yields one bubble.
- Back-to-back loads with a dependent third instruction produce at most one stall per dependence.
- Reset (`rst_n`=0, asynchronous, any cycle):
  - all shadow fields and counters clear to 0 immediately;
  - outputs become `pc_en`=1, `ifid_en`=1, `ifid_flush`=0, `fwd_a`=`fwd_b`=00, `idex_control`=`id_control`.
  - A pending stall is dropped.
- Reset release is synchronous to the next rising edge; the first edge with `rst_n`=1 loads EX normally.

## Test plan
- lw r2 then add r3,r2,r4: one cycle with `pc_en`=0, `ifid_en`=0, `idex_control`=0; next cycle add in EX with `fwd_a`=01; `cnt_paradas`=1.
- add r1 then sub r5,r1,r1: no stall; sub in EX sees `fwd_a`=`fwd_b`=10.
- Writes to r1 in MEM and WB simultaneously, EX reads r1: `fwd_a`=10. lw r0 followed by a reader of r0: no stall, `fwd`=00.
- `ex_salto_tomado`=1 in the same cycle as a load-use `parada`: `pc_en`=1, `ifid_flush`=1, `idex_control`=0; `cnt_paradas` unchanged, `cnt_vaciados`+1.
- Jump in ID: `ifid_flush`=1 for one cycle and `idex_control`=`id_control`. Jump in ID while stalled: `ifid_flush`=0 until the stall clears.
- Assert `rst_n`=0 mid-stall: `pc_en` returns to 1 asynchronously and counters read 0. Force `cnt_paradas` to 16'hFFFF and stall again: value stays 16'hFFFF.
